hilo_mdu: RTL and testbench

Multiply/divide unit with the architectural HI/LO registers for the 5-stage MIPS core. It sits in EX, alongside ALU1. Its operands come from the rs/rt forwarding muxes (mux4/mux5 outputs), and its RHLOut output feeds the RHLOut input (select 2'b00) of the EX result mux (mux6). It runs MULT/MULTU in a short fixed latency, runs DIV/DIVU iteratively, and performs MTHI/MTLO writes. While `busy` is high, the hazard unit stalls any HI/LO consumer.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/div_core.sv | 62 ++++++
 rtl/hilo_mdu.sv | 176 +++++++++++++++++
 tb/tb_hilo_mdu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mdu_pkg;

    // MDUOp encodings driven by the decoder
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    // One restoring step per data bit
    localparam int unsigned MDU_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } mdu_state_t;

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step.
// The dividend is held in the quotient register and shifted out MSB first
// while quotient bits are shifted in at the LSB.
module div_core #(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_last
);

    localparam int unsigned CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_ITERS - 1);

    logic [31:0]      r_rem;
    logic [31:0]      r_quot;
    logic [31:0]      r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [32:0]      w_shifted;
    logic [31:0]      w_diff;
    logic             w_ge;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_shifted = {r_rem, r_quot[31]};
        w_ge      = (w_shifted >= {1'b0, r_divisor});
        w_diff    = w_shifted[31:0] - r_divisor;
    end

    // Datapath registers: load operands or advance one step
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_cnt     <= CNT_INIT;
        end else if (i_step) begin
            r_rem  <= w_ge ? w_diff : w_shifted[31:0];
            r_quot <= {r_quot[30:0], w_ge};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned DIV_ITERS = MDU_DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RHLSel,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] RHLOut
);

    mdu_state_t  r_state;
    mdu_state_t  w_state_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_mul_signed;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_mul_load;
    logic        w_div_load;
    logic        w_div_step;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_d;
    logic [31:0] w_lo_d;

    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic        w_div_last;

    div_core #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_div_load),
        .i_step     (w_div_step),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_div_last)
    );

    // Operand magnitudes for division, product and sign fix-up
    always_comb begin
        w_div_signed = (MDUOp == MDU_DIV);
        w_abs_a      = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
        w_abs_b      = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
        w_mul_a      = {{32{r_mul_signed & r_op_a[31]}}, r_op_a};
        w_mul_b      = {{32{r_mul_signed & r_op_b[31]}}, r_op_b};
        w_product    = w_mul_a * w_mul_b;
        w_quot_fix   = r_neg_q ? (~w_quot + 32'd1) : w_quot;
        w_rem_fix    = r_neg_r ? (~w_rem + 32'd1) : w_rem;
    end

    // Next-state and HI/LO write control; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        w_mul_load   = 1'b0;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        w_hi_we      = 1'b0;
        w_lo_we      = 1'b0;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        MDU_MTHI: begin
                            w_hi_we = 1'b1;
                            w_hi_d  = A;
                        end
                        MDU_MTLO: begin
                            w_lo_we = 1'b1;
                            w_lo_d  = A;
                        end
                        MDU_MULT, MDU_MULTU: begin
                            w_mul_load   = 1'b1;
                            w_state_next = S_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_div_load   = 1'b1;
                            w_state_next = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                w_hi_we      = 1'b1;
                w_lo_we      = 1'b1;
                w_hi_d       = w_product[63:32];
                w_lo_d       = w_product[31:0];
                w_state_next = S_IDLE;
            end
            S_DIV: begin
                w_div_step = 1'b1;
                if (w_div_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_hi_we      = 1'b1;
                w_lo_we      = 1'b1;
                w_hi_d       = w_rem_fix;
                w_lo_d       = w_quot_fix;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
            w_mul_load   = 1'b0;
            w_div_load   = 1'b0;
            w_div_step   = 1'b0;
            w_hi_we      = 1'b0;
            w_lo_we      = 1'b0;
        end
    end

    // State, HI/LO and latched operand/sign registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hi         <= '0;
            r_lo         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_mul_signed <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_hi_we) begin
                r_hi <= w_hi_d;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_d;
            end
            if (w_mul_load) begin
                r_op_a       <= A;
                r_op_b       <= B;
                r_mul_signed <= (MDUOp == MDU_MULT);
            end
            if (w_div_load) begin
                r_neg_q <= w_div_signed & (A[31] ^ B[31]);
                r_neg_r <= w_div_signed & A[31];
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign RHLOut = RHLSel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu.
module tb_hilo_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        RHLSel;
    logic        flush;
    logic        busy;
    logic [31:0] RHLOut;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_cyc;
    } vec_t;

    vec_t vecs [12];

    hilo_mdu #(
        .DIV_ITERS (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .RHLSel (RHLSel),
        .flush  (flush),
        .busy   (busy),
        .RHLOut (RHLOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        RHLSel = 1'b0;
        #1;
        lo = RHLOut;
        RHLSel = 1'b1;
        #1;
        hi = RHLOut;
    endtask

    // Issue one op at a negedge, then count busy cycles (bounded)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        @(negedge clk);
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [31:0] hi;
    logic [31:0] lo;
    int          n;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        MDUOp  = 3'b000;
        A      = '0;
        B      = '0;
        RHLSel = 1'b0;
        flush  = 1'b0;

        // op, a, b, expected hi, expected lo, busy cycles
        vecs[0]  = '{3'b100, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{3'b000, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1};
        vecs[2]  = '{3'b001, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 1};
        vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[4]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[5]  = '{3'b011, 32'h55,       32'h0,        32'h00000055, 32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[7]  = '{3'b010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'h00000001, 33};
        vecs[8]  = '{3'b101, 32'hCAFEF00D, 32'h0,        32'hFFFFFFF9, 32'hCAFEF00D, 0};
        vecs[9]  = '{3'b111, 32'h11111111, 32'h2,        32'hFFFFFFF9, 32'hCAFEF00D, 0};
        vecs[10] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[11] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        read_hilo(hi, lo);
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, n);
            checks++;
            if (n != vecs[i].busy_cyc) begin
                errors++;
                $display("FAIL vec%0d_busy: got %0d cycles expected %0d", i, n, vecs[i].busy_cyc);
            end
            read_hilo(hi, lo);
            check32($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check32($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Flush in cycle t+10 of a DIV: HI/LO keep the pre-DIV values
        @(negedge clk);
        start = 1'b1;
        MDUOp = 3'b011;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before: got %b expected 1", busy);
        end
        read_hilo(hi, lo);
        check32("busy_old_hi", hi, 32'h40000000);
        check32("busy_old_lo", lo, 32'h00000000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_after: got %b expected 0", busy);
        end
        repeat (40) @(negedge clk);
        read_hilo(hi, lo);
        check32("flush_hi", hi, 32'h40000000);
        check32("flush_lo", lo, 32'h00000000);

        // MTHI together with flush must not write
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        MDUOp = 3'b100;
        A     = 32'h0000DEAD;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        read_hilo(hi, lo);
        check32("mthi_flush_hi", hi, 32'h40000000);

        // Reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1;
        MDUOp = 3'b010;
        A     = 32'hFFFFFFF9;
        B     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b expected 0", busy);
        end
        read_hilo(hi, lo);
        check32("rst_hi", hi, 32'h0);
        check32("rst_lo", lo, 32'h0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        read_hilo(hi, lo);
        check32("rst_stays_hi", hi, 32'h0);
        check32("rst_stays_lo", lo, 32'h0);

        issue(3'b000, 32'd3, 32'd5, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL mul35_busy: got %0d cycles expected 1", n);
        end
        read_hilo(hi, lo);
        check32("mul35_hi", hi, 32'h0);
        check32("mul35_lo", lo, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
